// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx serializer: FSM state encodings,
// serial line levels and a counter-width helper.
package uart_tx_pkg;

    // Frame states, 3-bit encoding shared by the FSM and anything decoding it.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // The line rests high between frames; the start bit pulls it low.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter width for a count of n: $clog2(n), never narrower than 1 bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for uart_tx: tick marks the last cycle of each bit time.
// The count runs 0..CLKS_PER_BIT-1 and wraps, so bit boundaries recur every
// CLKS_PER_BIT cycles; clear realigns the count to the start of a frame.
module bit_timer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned          CNT_W    = ctr_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Cycle counter: restart on clear or at each bit boundary, else advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start (0), DATA_W data bits LSB first, optional even parity, stop (1).
// Each bit is held CLKS_PER_BIT cycles. tx_ready is the only unregistered
// output; it is asserted whenever the FSM sits in IDLE.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for a valid/ready handshake
// ST_START  | driving the start bit (0) for one bit time
// ST_DATA   | driving shreg[0]; shifting right at each data-bit boundary
// ST_PARITY | driving the even-parity bit of the latched word
// ST_STOP   | driving the stop bit (1); tx_done pulses on its closing edge
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned      IDX_W    = ctr_width(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    tx_state_e         state;
    tx_state_e         state_nx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic [DATA_W-1:0] shreg_shift;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_nx;
    logic              parity_bit;
    logic              parity_nx;
    logic              tx_out_nx;
    logic              done_nx;
    logic              handshake;
    logic              tick;

    assign tx_ready    = (state == ST_IDLE);
    assign handshake   = tx_valid && tx_ready;
    assign shreg_shift = shreg >> 1;

    // The bit timer is realigned on the handshake so the start bit gets a full
    // bit time regardless of where the free-running count was while idle.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (handshake),
        .tick  (tick)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            tx_out     <= LINE_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_idx    <= bit_idx_nx;
            parity_bit <= parity_nx;
            tx_out     <= tx_out_nx;
            tx_busy    <= (state_nx != ST_IDLE);
            tx_done    <= done_nx;
        end
    end

    // Next-state and next-output decode; the line value for the coming bit is
    // computed here so tx_out changes on the same edge as the state.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        parity_nx  = parity_bit;
        tx_out_nx  = tx_out;
        done_nx    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tx_out_nx = LINE_IDLE;
                if (handshake) begin
                    state_nx   = ST_START;
                    shreg_nx   = tx_data;
                    parity_nx  = ^tx_data;
                    bit_idx_nx = '0;
                    tx_out_nx  = LINE_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nx   = ST_DATA;
                    bit_idx_nx = '0;
                    tx_out_nx  = shreg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_nx = shreg_shift;
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nx  = ST_PARITY;
                            tx_out_nx = parity_bit;
                        end else begin
                            state_nx  = ST_STOP;
                            tx_out_nx = LINE_IDLE;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                        tx_out_nx  = shreg_shift[0];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nx  = ST_STOP;
                    tx_out_nx = LINE_IDLE;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_nx  = ST_IDLE;
                    tx_out_nx = LINE_IDLE;
                    done_nx   = 1'b1;
                end
            end
            default: begin
                state_nx  = ST_IDLE;
                tx_out_nx = LINE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. Three instances cover the default build,
// the even-parity build and the CLKS_PER_BIT=1 / DATA_W=4 build.
// Expected frames are hand-written bit vectors, bit 0 = first bit on the line.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data_a  = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, out_a, busy_a, done_a;

    logic [7:0] data_p  = '0;
    logic       valid_p = 1'b0;
    logic       ready_p, out_p, busy_p, done_p;

    logic [3:0] data_c  = '0;
    logic       valid_c = 1'b0;
    logic       ready_c, out_c, busy_c, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
        .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .tx_data(data_p), .tx_valid(valid_p),
        .tx_ready(ready_p), .tx_out(out_p), .tx_busy(busy_p), .tx_done(done_p)
    );

    uart_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
        .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid_c),
        .tx_ready(ready_c), .tx_out(out_c), .tx_busy(busy_c), .tx_done(done_c)
    );

    // {ready, busy, done, out} of the selected instance.
    function automatic logic [3:0] mon(input int s);
        case (s)
            0:       return {ready_a, busy_a, done_a, out_a};
            1:       return {ready_p, busy_p, done_p, out_p};
            default: return {ready_c, busy_c, done_c, out_c};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin valid_a = v; data_a = d;      end
            1:       begin valid_p = v; data_p = d;      end
            default: begin valid_c = v; data_c = d[3:0]; end
        endcase
    endtask

    // Present a word, take the handshake edge, check the frame has started.
    task automatic handshake(input int s, input logic [7:0] d, input logic hold);
        logic [3:0] m;
        m = mon(s);
        chk("ready_before_hs", 32'(m[3]), 32'd1);
        drive(s, 1'b1, d);
        step();
        if (!hold) drive(s, 1'b0, d);
        m = mon(s);
        chk("ready_after_hs", 32'(m[3]), 32'd0);
    endtask

    // Called just after the handshake edge; returns just after the closing edge.
    task automatic run_frame(input int s, input logic [15:0] exp_bits,
                             input int nbits, input int cpb);
        logic [3:0] m;
        for (int j = 0; j < nbits * cpb; j++) begin
            m = mon(s);
            chk("line_bit",   32'(m[0]), 32'(exp_bits[j / cpb]));
            chk("done_early", 32'(m[1]), 32'd0);
            chk("busy_frame", 32'(m[2]), 32'd1);
            step();
        end
        m = mon(s);
        chk("done_pulse", 32'(m[1]), 32'd1);
        chk("ready_end",  32'(m[3]), 32'd1);
        chk("busy_end",   32'(m[2]), 32'd0);
        chk("line_stop",  32'(m[0]), 32'd1);
    endtask

    initial begin
        logic [3:0] m;

        // Reset held for two cycles with valid asserted on every instance.
        #2 rst = 1'b0;
        valid_a = 1'b1; data_a = 8'hA5;
        valid_p = 1'b1; data_p = 8'h07;
        valid_c = 1'b1; data_c = 4'h9;
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            m = mon(s);
            chk("rst_ready", 32'(m[3]), 32'd1);
            chk("rst_busy",  32'(m[2]), 32'd0);
            chk("rst_done",  32'(m[1]), 32'd0);
            chk("rst_line",  32'(m[0]), 32'd1);
        end
        valid_a = 1'b0; valid_p = 1'b0; valid_c = 1'b0;
        rst = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            m = mon(s);
            chk("post_rst_busy", 32'(m[2]), 32'd0);
        end

        // Default build, 8'hA5 -> 0,1,0,1,0,0,1,0,1,1.
        handshake(0, 8'hA5, 1'b0);
        run_frame(0, 16'h034A, 10, 4);
        step();
        m = mon(0);
        chk("done_one_cycle", 32'(m[1]), 32'd0);

        // Even parity: A5 has four ones -> parity 0; 07 has three -> parity 1.
        handshake(1, 8'hA5, 1'b0);
        run_frame(1, 16'h054A, 11, 4);
        step();
        handshake(1, 8'h07, 1'b0);
        run_frame(1, 16'h060E, 11, 4);
        step();

        // Back-to-back with valid held; mid-frame data and valid changes ignored.
        handshake(0, 8'h3C, 1'b1);
        fork
            run_frame(0, 16'h0278, 10, 4);
            begin
                repeat (8) step();
                data_a = 8'hC3;
                repeat (4) step();
                valid_a = 1'b0;
                step();
                valid_a = 1'b1;
            end
        join
        step();
        valid_a = 1'b0;
        data_a  = 8'h00;
        m = mon(0);
        chk("b2b_start_41", 32'(m[0]), 32'd0);
        chk("b2b_busy",     32'(m[2]), 32'd1);
        run_frame(0, 16'h0386, 10, 4);
        step();

        // Reset during data bit 3 (cycles 16..19 after the handshake).
        handshake(0, 8'hA5, 1'b0);
        repeat (17) step();
        m = mon(0);
        chk("pre_abort_bit3", 32'(m[0]), 32'd0);
        #2 rst = 1'b0;
        #1;
        m = mon(0);
        chk("abort_line",  32'(m[0]), 32'd1);
        chk("abort_busy",  32'(m[2]), 32'd0);
        chk("abort_ready", 32'(m[3]), 32'd1);
        chk("abort_done",  32'(m[1]), 32'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 45; k++) begin
            m = mon(0);
            chk("abort_no_done", 32'(m[1]), 32'd0);
            chk("abort_idle",    32'(m[0]), 32'd1);
            step();
        end
        handshake(0, 8'h55, 1'b0);
        run_frame(0, 16'h02AA, 10, 4);
        step();

        // One clock per bit, 4-bit word 1001 -> 0,1,0,0,1,1.
        handshake(2, 8'h09, 1'b0);
        run_frame(2, 16'h0032, 6, 1);
        step();
        m = mon(2);
        chk("c1_done_one_cycle", 32'(m[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
